// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control sequencer for the 32-bit processor
module instr_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [3:0]      alu_opsel,
    output logic            alu_b_sel,
    output logic            wb_sel,
    output logic            rf_we,
    output logic            dmem_re,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [15:0]     retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    state_t          state, nxt;
    logic [PC_W-1:0] pc, pc_n;
    logic [31:0]     ir_n;
    logic [WW-1:0]   wcnt, wcnt_n;
    logic [15:0]     ret_n;
    logic            err_n, done, timeout, dv;
    logic [3:0]      fx, fxn;

    assign imem_addr = pc;
    assign fx        = ir[18:15];
    assign fxn       = ir_n[18:15];
    assign timeout   = (wcnt + 1'b1) == WAIT_MAX;

    // next state, next architectural registers and handshake wait counting
    always_comb begin
        nxt    = state;
        pc_n   = pc;
        ir_n   = ir;
        wcnt_n = '0;
        err_n  = err;
        ret_n  = retired;
        done   = 1'b0;
        case (state)
            IDLE:   nxt = run ? FETCH : IDLE;
            FETCH:  begin
                if (imem_ready) begin
                    ir_n = imem_rdata;
                    pc_n = pc + 1'b1;
                    nxt  = DECODE;
                end else if (timeout) begin
                    err_n = 1'b1;
                    nxt   = HALT;
                end else wcnt_n = wcnt + 1'b1;
            end
            DECODE: begin
                nxt  = (fx == 4'hf) ? HALT : EXEC;
                done = fx == 4'he;
            end
            EXEC:   nxt = (fx[3:1] == 3'b110) ? MEM : WB;
            MEM:    begin
                if (dmem_ready) begin
                    nxt  = WB;
                    done = fx == 4'hd;
                end else if (timeout) begin
                    err_n = 1'b1;
                    nxt   = HALT;
                end else wcnt_n = wcnt + 1'b1;
            end
            WB:     done = 1'b1;
            HALT:   nxt = HALT;
            default: nxt = IDLE;
        endcase
        if (done) begin
            ret_n = retired + 1'b1;
            nxt   = run ? FETCH : IDLE;
        end
    end

    assign dv = nxt == DECODE || nxt == EXEC || nxt == MEM || nxt == WB;

    // state registers plus Moore outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            wcnt      <= '0;
            err       <= 1'b0;
            retired   <= '0;
            imem_req  <= 1'b0;
            alu_opsel <= '0;
            alu_b_sel <= 1'b0;
            wb_sel    <= 1'b0;
            rf_we     <= 1'b0;
            dmem_re   <= 1'b0;
            dmem_we   <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= nxt;
            pc        <= pc_n;
            ir        <= ir_n;
            wcnt      <= wcnt_n;
            err       <= err_n;
            retired   <= ret_n;
            imem_req  <= nxt == FETCH;
            alu_opsel <= (dv && fxn < 4'hc) ? fxn : 4'h0;
            alu_b_sel <= dv && (fxn[3:1] == 3'b110 || (fxn < 4'hc && ir_n[31]));
            wb_sel    <= dv && fxn == 4'hc;
            rf_we     <= nxt == WB;
            dmem_re   <= nxt == MEM && fxn == 4'hc;
            dmem_we   <= nxt == MEM && fxn == 4'hd;
            busy      <= nxt != IDLE && nxt != HALT;
            halted    <= nxt == HALT;
        end
    end
endmodule
